// File: rtl/id_ex_reg.sv
`timescale 1ns/1ps
// id_ex_reg: ID/EX pipeline register with flush/stall priority, valid tracking and saturating bubble counter
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [1:0]        control_WB,
  input  logic [1:0]        control_MEM,
  input  logic [3:0]        control_EX,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [4:0]        rs_addr_i,
  input  logic [4:0]        rt_addr_i,
  input  logic [4:0]        rd_addr_i,
  output logic [1:0]        ctrl_WB_o,
  output logic [1:0]        ctrl_MEM_o,
  output logic [3:0]        ctrl_EX_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [4:0]        rs_addr_o,
  output logic [4:0]        rt_addr_o,
  output logic [4:0]        rd_addr_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);
  localparam int PW = 8 + 4 * DATA_W + 15;
  typedef enum logic {RUN, HOLD} state_e;
  state_e           state_q, state_d;
  logic [PW-1:0]    pl_q, pl_d, in_pl;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bubble, stay_hold, cnt_en;
  assign in_pl = {control_WB, control_MEM, control_EX, pc_i, rs_data_i, rt_data_i, imm_i,
                  rs_addr_i, rt_addr_i, rd_addr_i};
  assign {ctrl_WB_o, ctrl_MEM_o, ctrl_EX_o, pc_o, rs_data_o, rt_data_o, imm_o,
          rs_addr_o, rt_addr_o, rd_addr_o} = pl_q;
  assign valid_o      = valid_q;
  assign bubble_cnt_o = cnt_q;
  // next state: flush clears, stall holds, otherwise load; count bubbles only on edges that actually load one
  always_comb begin
    bubble    = ~|{control_WB, control_MEM, control_EX};
    stay_hold = (state_q == HOLD) & stall_i & ~flush_i;
    cnt_en    = flush_i | (~stall_i & bubble & ~stay_hold);
    pl_d      = flush_i ? '0 : stall_i ? pl_q : in_pl;
    valid_d   = flush_i ? 1'b0 : stall_i ? valid_q : ~bubble;
    state_d   = (stall_i & ~flush_i) ? HOLD : RUN;
    cnt_d     = (cnt_en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  // all state registers, cleared immediately by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      pl_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pl_q    <= pl_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_id_ex_reg.sv
`timescale 1ns/1ps
// tb_id_ex_reg: randomized and directed checks of id_ex_reg against a behavioural model
module tb_id_ex_reg;
  logic clk_i = 1'b0, rst_i = 1'b1, stall_i = 1'b0, flush_i = 1'b0;
  logic [1:0] control_WB = '0, control_MEM = '0;
  logic [3:0] control_EX = '0;
  logic [31:0] pc_i = '0, rs_data_i = '0, rt_data_i = '0, imm_i = '0;
  logic [4:0] rs_addr_i = '0, rt_addr_i = '0, rd_addr_i = '0;
  logic [1:0] ctrl_WB_o, ctrl_MEM_o;
  logic [3:0] ctrl_EX_o;
  logic [31:0] pc_o, rs_data_o, rt_data_o, imm_o;
  logic [4:0] rs_addr_o, rt_addr_o, rd_addr_o;
  logic valid_o;
  logic [3:0] bubble_cnt_o;
  logic [1:0] m_wb, m_mem;
  logic [3:0] m_ex;
  logic [31:0] m_pc, m_rs, m_rt, m_imm;
  logic [4:0] m_rsa, m_rta, m_rda;
  logic m_valid;
  logic [3:0] m_cnt;
  logic [155:0] dut_v, exp_v;
  int checks = 0, errors = 0;

  id_ex_reg #(.DATA_W(32), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .control_WB(control_WB), .control_MEM(control_MEM), .control_EX(control_EX),
    .pc_i(pc_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
    .ctrl_WB_o(ctrl_WB_o), .ctrl_MEM_o(ctrl_MEM_o), .ctrl_EX_o(ctrl_EX_o),
    .pc_o(pc_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
    .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o),
    .valid_o(valid_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  assign dut_v = {ctrl_WB_o, ctrl_MEM_o, ctrl_EX_o, pc_o, rs_data_o, rt_data_o, imm_o,
                  rs_addr_o, rt_addr_o, rd_addr_o, valid_o, bubble_cnt_o};
  assign exp_v = {m_wb, m_mem, m_ex, m_pc, m_rs, m_rt, m_imm, m_rsa, m_rta, m_rda, m_valid, m_cnt};

  task automatic model_reset();
    {m_wb, m_mem, m_ex, m_pc, m_rs, m_rt, m_imm, m_rsa, m_rta, m_rda, m_valid} = '0;
    m_cnt = 4'd0;
  endtask

  task automatic model_bump();
    if (m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
  endtask

  // one clock edge of the ID/EX slot as seen from the pipeline
  task automatic model_edge();
    if (flush_i) begin
      {m_wb, m_mem, m_ex, m_pc, m_rs, m_rt, m_imm, m_rsa, m_rta, m_rda, m_valid} = '0;
      model_bump();
    end else if (!stall_i) begin
      {m_wb, m_mem, m_ex} = {control_WB, control_MEM, control_EX};
      {m_pc, m_rs, m_rt, m_imm} = {pc_i, rs_data_i, rt_data_i, imm_i};
      {m_rsa, m_rta, m_rda} = {rs_addr_i, rt_addr_i, rd_addr_i};
      m_valid = (control_WB != 0) || (control_MEM != 0) || (control_EX != 0);
      if (!m_valid) model_bump();
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    if (!rst_i) model_edge();
    #1;
  endtask

  task automatic rand_inputs();
    if ($urandom_range(3) == 0) {control_WB, control_MEM, control_EX} = '0;
    else {control_WB, control_MEM, control_EX} = 8'($urandom);
    pc_i = $urandom; rs_data_i = $urandom; rt_data_i = $urandom; imm_i = $urandom;
    rs_addr_i = 5'($urandom); rt_addr_i = 5'($urandom); rd_addr_i = 5'($urandom);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    model_reset();
    step();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (dut_v !== 156'd0) begin errors++; $display("FAIL reset_immediate: got %h want 0", dut_v); end
    rand_inputs();
    step();
    checks++;
    if (dut_v !== 156'd0) begin errors++; $display("FAIL reset_held_edge: got %h want 0", dut_v); end
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_load();
    rand_inputs();
    control_WB = 2'b10; control_MEM = 2'b01; control_EX = 4'b1100; pc_i = 32'h40; rs_data_i = 32'h5;
    step();
    checks++;
    if (dut_v !== exp_v) begin errors++; $display("FAIL load: got %h want %h", dut_v, exp_v); end
    checks++;
    if ({ctrl_WB_o, ctrl_MEM_o, ctrl_EX_o, pc_o, rs_data_o, valid_o, bubble_cnt_o} !== {8'b10011100, 32'h40, 32'h5, 1'b1, 4'd0}) begin
      errors++; $display("FAIL load_fields: got pc=%h rs=%h v=%b cnt=%0d want pc=40 rs=5 v=1 cnt=0", pc_o, rs_data_o, valid_o, bubble_cnt_o);
    end
  endtask

  task automatic test_stall();
    @(negedge clk_i);
    stall_i = 1'b1; pc_i = 32'h44;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc_o !== 32'h40 || valid_o !== 1'b1 || dut_v !== exp_v) begin
        errors++; $display("FAIL stall_hold[%0d]: got pc=%h v=%b want pc=40 v=1", i, pc_o, valid_o);
      end
    end
    @(negedge clk_i);
    stall_i = 1'b0;
    step();
    checks++;
    if (pc_o !== 32'h44 || dut_v !== exp_v) begin errors++; $display("FAIL stall_release: got pc=%h want 44", pc_o); end
  endtask

  task automatic test_bubble_flush();
    @(negedge clk_i);
    rand_inputs();
    {control_WB, control_MEM, control_EX} = '0;
    step();
    checks++;
    if (valid_o !== 1'b0 || bubble_cnt_o !== 4'd1 || dut_v !== exp_v) begin
      errors++; $display("FAIL bubble: got v=%b cnt=%0d want v=0 cnt=1", valid_o, bubble_cnt_o);
    end
    @(negedge clk_i);
    rand_inputs();
    control_EX = 4'b0011; flush_i = 1'b1;
    step();
    checks++;
    if (dut_v !== {152'd0, 4'd2}) begin errors++; $display("FAIL flush: got %h want cnt=2 rest 0", dut_v); end
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  task automatic test_partial();
    @(negedge clk_i);
    rand_inputs();
    control_WB = 2'b00; control_MEM = 2'b00; control_EX = 4'b0100;
    step();
    checks++;
    if (valid_o !== 1'b1 || dut_v !== exp_v) begin errors++; $display("FAIL partial_ctrl: got v=%b cnt=%0d want v=1 cnt=%0d", valid_o, bubble_cnt_o, m_cnt); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk_i);
    rand_inputs();
    control_WB = 2'b11; stall_i = 1'b1;
    step();
    @(negedge clk_i);
    flush_i = 1'b1;
    step();
    checks++;
    if (dut_v !== exp_v || valid_o !== 1'b0 || pc_o !== 32'd0) begin errors++; $display("FAIL stall_flush: got %h want %h", dut_v, exp_v); end
    @(negedge clk_i);
    flush_i = 1'b0; stall_i = 1'b0;
    rand_inputs();
    control_MEM = 2'b10;
    step();
    checks++;
    if (dut_v !== exp_v || pc_o !== pc_i || valid_o !== 1'b1) begin errors++; $display("FAIL after_stall_flush: got %h want %h", dut_v, exp_v); end
  endtask

  task automatic test_saturation();
    do_reset();
    flush_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      step();
      checks++;
      if (dut_v !== exp_v) begin errors++; $display("FAIL saturate[%0d]: got cnt=%0d want %0d", i, bubble_cnt_o, m_cnt); end
      @(negedge clk_i);
    end
    flush_i = 1'b0;
    checks++;
    if (bubble_cnt_o !== 4'd15) begin errors++; $display("FAIL saturate_final: got %0d want 15", bubble_cnt_o); end
  endtask

  task automatic test_async_reset();
    rand_inputs();
    control_EX = 4'b1000;
    step();
    @(negedge clk_i);
    stall_i = 1'b1;
    step();
    step();
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_v !== 156'd0) begin errors++; $display("FAIL async_reset: got %h want 0", dut_v); end
    @(negedge clk_i);
    rst_i = 1'b0; stall_i = 1'b0;
    rand_inputs();
    control_WB = 2'b01;
    step();
    checks++;
    if (dut_v !== exp_v || pc_o !== pc_i || valid_o !== 1'b1) begin errors++; $display("FAIL reset_then_load: got %h want %h", dut_v, exp_v); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      stall_i = ($urandom_range(2) == 0);
      flush_i = ($urandom_range(7) == 0);
      step();
      checks++;
      if (dut_v !== exp_v) begin errors++; $display("FAIL random[%0d]: got %h want %h", i, dut_v, exp_v); end
      @(negedge clk_i);
    end
    stall_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_stall();
    test_bubble_flush();
    test_partial();
    test_simultaneous();
    test_saturation();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
